// File: rtl/imm_encoder_if.sv
// Request/result handshake bundle for imm_encoder.
// master = upstream/downstream environment, slave = the encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSrc;
  logic [31:0] imm;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic        range_err;
  logic [15:0] enc_count;

  modport master (
    output in_valid, ImmSrc, imm, base_instr, out_ready,
    input  in_ready, out_valid, instr_out, range_err, enc_count
  );

  modport slave (
    input  in_valid, ImmSrc, imm, base_instr, out_ready,
    output in_ready, out_valid, instr_out, range_err, enc_count
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage pipelined RISC-V immediate encoder with valid/ready handshakes.
// Optional range checking is enabled by defining IMM_RANGE_CHECK_EN.
module imm_encoder (
  input  logic          clk,
  input  logic          rst,
  imm_encoder_if.slave  bus
);
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100
  } fmt_e;

  logic        v1;
  fmt_e        src1;
  logic [31:0] imm1;
  logic [31:0] base1;

  logic        v2;
  logic [31:0] instr2;
  logic        err2;

  logic [15:0] count;

  logic        s1_load;
  logic        s2_load;
  logic [31:0] enc;
  logic        err;

  // S1 advances whenever S2 will make room, so in_ready equals s1_load.
  assign s2_load = !v2 || bus.out_ready;
  assign s1_load = !v1 || s2_load;

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = v2;
  assign bus.instr_out = instr2;
  assign bus.range_err = err2;
  assign bus.enc_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      src1  <= FMT_I;
      imm1  <= '0;
      base1 <= '0;
    end else if (s1_load) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        src1  <= fmt_e'(bus.ImmSrc);
        imm1  <= bus.imm;
        base1 <= bus.base_instr;
      end
    end
  end

  always_comb begin
    enc = base1;
    case (src1)
      FMT_I: enc[31:20] = imm1[11:0];
      FMT_S: begin
        enc[31:25] = imm1[11:5];
        enc[11:7]  = imm1[4:0];
      end
      FMT_B: begin
        enc[31]    = imm1[12];
        enc[30:25] = imm1[10:5];
        enc[11:8]  = imm1[4:1];
        enc[7]     = imm1[11];
      end
      FMT_U: enc[31:12] = imm1[31:12];
      FMT_J: begin
        enc[31]    = imm1[20];
        enc[30:21] = imm1[10:1];
        enc[20]    = imm1[11];
        enc[19:12] = imm1[19:12];
      end
      default: ;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Representable iff all bits above the field's sign bit replicate it.
  always_comb begin
    err = 1'b0;
    case (src1)
      FMT_I, FMT_S: err = (imm1[31:11] != {21{imm1[11]}});
      FMT_B:        err = imm1[0] || (imm1[31:12] != {20{imm1[12]}});
      FMT_U:        err = (imm1[11:0] != 12'h000);
      FMT_J:        err = imm1[0] || (imm1[31:20] != {12{imm1[20]}});
      default:      err = 1'b1;
    endcase
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      instr2 <= '0;
      err2   <= 1'b0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        instr2 <= enc;
        err2   <= err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (v2 && bus.out_ready && (count != '1)) begin
      count <= count + 16'd1;
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: encodings, range flags,
// backpressure, and mid-stream reset.
module tb_imm_encoder;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request through an empty pipeline with out_ready held high.
  task automatic xact(input string tag, input logic [2:0] src, input logic [31:0] im,
                      input logic [31:0] base, input logic [31:0] ei, input logic ee);
    int unsigned n;
    @(negedge clk);
    bus.ImmSrc = src; bus.imm = im; bus.base_instr = base;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.imm = 32'hA5A5A5A5; bus.base_instr = 32'h5A5A5A5A; bus.ImmSrc = 3'b110;
    n = 1;
    while (!bus.out_valid && n < 6) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd2);
    chk({tag, "_instr"}, bus.instr_out, ei);
    chk({tag, "_err"}, {31'b0, bus.range_err}, {31'b0, ee});
  endtask

  logic [31:0] bp_exp [4];
  int unsigned idx_in;
  int unsigned idx_out;
  int unsigned cyc;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.ImmSrc = 3'b000; bus.imm = '0; bus.base_instr = '0;

    #12;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_instr", bus.instr_out, 32'd0);
    chk("rst_err", {31'b0, bus.range_err}, 32'd0);
    chk("rst_count", {16'b0, bus.enc_count}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    xact("I_neg1",  3'b000, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0);
    xact("S_8",     3'b001, 32'h00000008, 32'h00002023, 32'h00002423, 1'b0);
    xact("B_8",     3'b010, 32'h00000008, 32'h00000063, 32'h00000463, 1'b0);
    xact("U",       3'b011, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
    xact("J_800",   3'b100, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0);
    xact("B_m4",    3'b010, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0);
    xact("J_m2",    3'b100, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 1'b0);
    xact("I_2047",  3'b000, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0);
    xact("I_m2048", 3'b000, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0);
    xact("I_2048",  3'b000, 32'h00000800, 32'h00000013, 32'h80000013, RC);
    xact("B_3",     3'b010, 32'h00000003, 32'h00000063, 32'h00000163, RC);
    xact("U_low",   3'b011, 32'h12345678, 32'h00000037, 32'h12345037, RC);
    xact("ill_111", 3'b111, 32'h00000004, 32'hDEADBEEF, 32'hDEADBEEF, RC);
    @(negedge clk);
    chk("count_13", {16'b0, bus.enc_count}, 32'd13);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("count_cleared", {16'b0, bus.enc_count}, 32'd0);

    // Backpressure: I-type encodings of imm=1..4 on base 0x13.
    bp_exp[0] = 32'h00100013; bp_exp[1] = 32'h00200013;
    bp_exp[2] = 32'h00300013; bp_exp[3] = 32'h00400013;
    bus.out_ready = 1'b0; bus.ImmSrc = 3'b000; bus.base_instr = 32'h00000013;
    bus.in_valid = 1'b1; bus.imm = 32'd1;
    #1;
    chk("bp_rdy0", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.imm = 32'd2;
    #1;
    chk("bp_rdy1", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.imm = 32'd3;
    #1;
    chk("bp_rdy_fall", {31'b0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_stall_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_stall_data", bus.instr_out, bp_exp[0]);
      chk("bp_stall_rdy", {31'b0, bus.in_ready}, 32'd0);
    end
    idx_in = 2; idx_out = 0; cyc = 0;
    bus.out_ready = 1'b1;
    while (idx_out < 4 && cyc < 20) begin
      bus.in_valid = (idx_in < 4);
      bus.imm = idx_in + 1;
      #1;
      if (bus.out_valid) begin
        chk("bp_order", bus.instr_out, bp_exp[idx_out]);
        idx_out++;
      end
      if (bus.in_valid && bus.in_ready) idx_in++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("bp_drained", idx_out, 32'd4);
    chk("bp_count", {16'b0, bus.enc_count}, 32'd4);

    // Mid-stream reset with both stages occupied.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.imm = 32'd9;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("mid_full", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_count", {16'b0, bus.enc_count}, 32'd0);
    chk("mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("mid_no_stale", {31'b0, bus.out_valid}, 32'd0);
    end
    xact("post_rst", 3'b001, 32'h00000008, 32'h00002023, 32'h00002423, 1'b0);
    @(negedge clk);
    chk("post_count", {16'b0, bus.enc_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
